// File: rtl/funct_generator_pkg.sv
// -----------------------------------------------------------------------------
// funct_generator_pkg
// Shared defaults and types for the funct_generator sample datapath.
//   FGEN_DATA_WIDTH  : default sample bus width
//   FGEN_PIPE_STAGES : default depth of the elastic retiming pipe
//   sample_t         : sample word at the default width
//   fgen_occ_width() : width of an occupancy counter able to hold 0..stages
// -----------------------------------------------------------------------------
package funct_generator_pkg;

    localparam int FGEN_DATA_WIDTH  = 32;
    localparam int FGEN_PIPE_STAGES = 2;

    typedef logic [FGEN_DATA_WIDTH-1:0] sample_t;

    // Occupancy counts 0..stages inclusive, so it needs one extra code point.
    function automatic int fgen_occ_width(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage : funct_generator_pkg

// File: rtl/funct_generator_register.sv
// -----------------------------------------------------------------------------
// funct_generator_register
// One data stage of the funct_generator retiming pipe: a WIDTH-bit register
// with async reset, synchronous clear and load enable.
//   clk   in   clock, posedge
//   rst   in   async reset, active-high, loads RESET_VALUE
//   clrh  in   sync clear, active-high, loads RESET_VALUE (priority over enh)
//   enh   in   load enable, active-high
//   d     in   next data word
//   q     out  registered data word
// -----------------------------------------------------------------------------
module funct_generator_register
    import funct_generator_pkg::*;
#(
    parameter int                WIDTH       = FGEN_DATA_WIDTH,
    parameter logic [WIDTH-1:0]  RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clrh,
    input  logic             enh,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // Data register: reset/clear to RESET_VALUE, otherwise load when enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= RESET_VALUE;
        end else if (clrh) begin
            r_q <= RESET_VALUE;
        end else if (enh) begin
            r_q <= d;
        end else begin
            r_q <= r_q;
        end
    end

    assign q = r_q;

endmodule : funct_generator_register

// File: rtl/funct_generator_pipe_reg.sv
// -----------------------------------------------------------------------------
// funct_generator_pipe_reg
// Elastic valid/ready pipeline register, STAGES deep and DATA_WIDTH wide, that
// retimes the funct_generator sample bus into the FIFO. Bubbles collapse: a
// stage advances whenever it is empty or the stage after it advances, so the
// pipe fills up under backpressure and never drops or duplicates a word.
//
// Parameters
//   DATA_WIDTH   payload width per stage (>=1)
//   STAGES       number of register stages (>=1), latency when unstalled
//   RESET_VALUE  data value loaded on rst or clrh
// Ports
//   clk        in   clock, posedge
//   rst        in   async reset, active-high
//   clrh       in   sync flush, active-high, priority over enh
//   enh        in   global advance enable, active-high
//   in_valid   in   upstream word valid
//   in_ready   out  pipe accepts in_data this cycle
//   in_data    in   upstream word
//   out_valid  out  last stage valid
//   out_ready  in   downstream accepts out_data
//   out_data   out  last stage data
//   occupancy  out  registered count of valid stages
//                   (present only when FGEN_PIPE_OCC_EN is defined)
//
// Configuration macro: FGEN_PIPE_OCC_EN adds the occupancy counter and port.
// -----------------------------------------------------------------------------
module funct_generator_pipe_reg
    import funct_generator_pkg::*;
#(
    parameter int                    DATA_WIDTH  = FGEN_DATA_WIDTH,
    parameter int                    STAGES      = FGEN_PIPE_STAGES,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = {DATA_WIDTH{1'b0}}
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  clrh,
    input  logic                                  enh,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [DATA_WIDTH-1:0]                 in_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
`ifdef FGEN_PIPE_OCC_EN
    output logic [fgen_occ_width(STAGES)-1:0]     occupancy,
`endif
    output logic [DATA_WIDTH-1:0]                 out_data
);

    logic [STAGES-1:0]     r_valid;
    logic [STAGES-1:0]     w_valid_nxt;
    logic [STAGES-1:0]     w_move;
    logic [DATA_WIDTH-1:0] w_stage_d [STAGES];
    logic [DATA_WIDTH-1:0] w_stage_q [STAGES];

    // Move chain from the output back to the input: a stage may advance when it
    // holds nothing or when its successor advances out of the way.
    always_comb begin
        w_move = {STAGES{1'b0}};
        w_move[STAGES-1] = enh & (~r_valid[STAGES-1] | out_ready);
        for (int i = STAGES - 2; i >= 0; i--) begin
            w_move[i] = enh & (~r_valid[i] | w_move[i+1]);
        end
    end

    // Next valid vector: a moving stage takes its predecessor's valid bit
    // (stage 0 takes in_valid), so a bubble entering a stage clears it.
    always_comb begin
        w_valid_nxt = r_valid;
        if (w_move[0]) begin
            w_valid_nxt[0] = in_valid;
        end else begin
            w_valid_nxt[0] = r_valid[0];
        end
        for (int i = 1; i < STAGES; i++) begin
            if (w_move[i]) begin
                w_valid_nxt[i] = r_valid[i-1];
            end else begin
                w_valid_nxt[i] = r_valid[i];
            end
        end
    end

    // Valid bits: async reset, flush on clrh, otherwise follow the move chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= {STAGES{1'b0}};
        end else if (clrh) begin
            r_valid <= {STAGES{1'b0}};
        end else begin
            r_valid <= w_valid_nxt;
        end
    end

    // Data stages. Data is loaded on every move, even behind a bubble; the
    // valid bit alone decides whether the word is meaningful.
    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign w_stage_d[g] = in_data;
        end else begin : g_body
            assign w_stage_d[g] = w_stage_q[g-1];
        end

        funct_generator_register #(
            .WIDTH       (DATA_WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage_reg (
            .clk  (clk),
            .rst  (rst),
            .clrh (clrh),
            .enh  (w_move[g]),
            .d    (w_stage_d[g]),
            .q    (w_stage_q[g])
        );
    end : g_stage

    // The upstream sees ready only when stage 0 really loads a word; a flush
    // or reset cycle never accepts.
    assign in_ready  = w_move[0] & ~clrh & ~rst;
    assign out_valid = r_valid[STAGES-1];
    assign out_data  = w_stage_q[STAGES-1];

`ifdef FGEN_PIPE_OCC_EN
    localparam int OCC_W = fgen_occ_width(STAGES);

    logic [OCC_W-1:0] r_occupancy;

    // Number of set bits in a valid vector.
    function automatic logic [OCC_W-1:0] count_valid(input logic [STAGES-1:0] v);
        logic [OCC_W-1:0] cnt;
        cnt = {OCC_W{1'b0}};
        for (int i = 0; i < STAGES; i++) begin
            cnt = cnt + OCC_W'(v[i]);
        end
        return cnt;
    endfunction

    // Occupancy is registered from the same next-state vector as the valid
    // bits, so it always equals popcount(r_valid).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occupancy <= {OCC_W{1'b0}};
        end else if (clrh) begin
            r_occupancy <= {OCC_W{1'b0}};
        end else begin
            r_occupancy <= count_valid(w_valid_nxt);
        end
    end

    assign occupancy = r_occupancy;
`endif

endmodule : funct_generator_pipe_reg

// File: tb/tb_funct_generator_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_funct_generator_pipe_reg
// Scoreboard bench for funct_generator_pipe_reg: a 3-stage and a 1-stage
// instance (DATA_WIDTH=8, RESET_VALUE=8'hA5). Stimulus pushes the expected
// word when the pipe accepts it; per-instance monitors pop and compare on
// every output transfer and check that a stalled output stays stable.
// -----------------------------------------------------------------------------
module tb_funct_generator_pipe_reg;

    localparam logic [7:0] RV = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic       clrh3, enh3, iv3, ir3, ov3, or3;
    logic [7:0] id3, od3;
    logic       clrh1, enh1, iv1, ir1, ov1, or1;
    logic [7:0] id1, od1;
`ifdef FGEN_PIPE_OCC_EN
    logic [1:0] occ3;
    logic       occ1;
`endif

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] q3 [$];
    logic [7:0] q1 [$];

    always #5 clk = ~clk;

    funct_generator_pipe_reg #(.DATA_WIDTH(8), .STAGES(3), .RESET_VALUE(RV)) u3 (
        .clk(clk), .rst(rst), .clrh(clrh3), .enh(enh3),
        .in_valid(iv3), .in_ready(ir3), .in_data(id3),
        .out_valid(ov3), .out_ready(or3),
`ifdef FGEN_PIPE_OCC_EN
        .occupancy(occ3),
`endif
        .out_data(od3)
    );

    funct_generator_pipe_reg #(.DATA_WIDTH(8), .STAGES(1), .RESET_VALUE(RV)) u1 (
        .clk(clk), .rst(rst), .clrh(clrh1), .enh(enh1),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1),
`ifdef FGEN_PIPE_OCC_EN
        .occupancy(occ1),
`endif
        .out_data(od1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitors ----------------
    logic       stall3 = 1'b0, stall1 = 1'b0;
    logic [7:0] hold3, hold1;

    always @(negedge clk) begin
        logic [7:0] e;
        if (rst || clrh3) begin
            q3.delete();
            stall3 = 1'b0;
        end else begin
            if (stall3) begin
                check("hold3_valid", ov3, 1);
                check("hold3_data", od3, hold3);
            end
            if (ov3 && or3 && enh3) begin
                if (q3.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL sb3_spurious: got %0h, expected no output", od3);
                end else begin
                    e = q3.pop_front();
                    check("sb3_data", od3, e);
                end
            end
            stall3 = ov3 && !(or3 && enh3);
            hold3  = od3;
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (rst || clrh1) begin
            q1.delete();
            stall1 = 1'b0;
        end else begin
            if (stall1) begin
                check("hold1_valid", ov1, 1);
                check("hold1_data", od1, hold1);
            end
            if (ov1 && or1 && enh1) begin
                if (q1.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL sb1_spurious: got %0h, expected no output", od1);
                end else begin
                    e = q1.pop_front();
                    check("sb1_data", od1, e);
                end
            end
            stall1 = ov1 && !(or1 && enh1);
            hold1  = od1;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Present d, wait (bounded) for acceptance, push exp, drop valid after the edge.
    task automatic push(input int sel, input logic [7:0] d, input logic [7:0] exp, output int waited);
        waited = 0;
        if (sel == 3) begin iv3 = 1'b1; id3 = d; end
        else          begin iv1 = 1'b1; id1 = d; end
        @(negedge clk);
        while (!((sel == 3) ? ir3 : ir1) && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 50) begin
            n_checks++; n_fail++;
            $display("FAIL push_timeout: word %0h not accepted within 50 cycles", d);
        end else if (sel == 3) begin
            q3.push_back(exp);
        end else begin
            q1.push_back(exp);
        end
        @(posedge clk); #1;
        if (sel == 3) iv3 = 1'b0; else iv1 = 1'b0;
    endtask

    task automatic drain(input int sel);
        int n = 0;
        while (n < 100 && (((sel == 3) ? (q3.size() != 0 || ov3) : (q1.size() != 0 || ov1)))) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: pipe %0d still holds words", sel);
        end
        @(posedge clk); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int w;
        int tot;
        logic [7:0] stream_tab [8];
        logic [7:0] s1_tab [4];
        stream_tab = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        s1_tab     = '{8'h55, 8'h56, 8'h57, 8'h58};

        rst = 1'b1;
        clrh3 = 1'b0; enh3 = 1'b1; iv3 = 1'b0; or3 = 1'b1; id3 = 8'h00;
        clrh1 = 1'b0; enh1 = 1'b1; iv1 = 1'b0; or1 = 1'b1; id1 = 8'h00;

        // 1: reset state
        #12;
        check("rst_out_valid", ov3, 0);
        check("rst_out_data", od3, RV);
        check("rst_in_ready", ir3, 0);
        check("rst1_out_data", od1, RV);
`ifdef FGEN_PIPE_OCC_EN
        check("rst_occupancy", occ3, 0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 2: streaming 01..08, latency 3 then one word per cycle
        tot = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    push(3, stream_tab[i], stream_tab[i], w);
                    tot += w;
                end
            end
            begin
                int n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!(iv3 && ir3) && n < 20);
                repeat (3) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    check("lat_valid", ov3, 1);
                    check("lat_data", od3, 8'(k + 1));
                    if (k < 7) @(negedge clk);
                end
            end
        join
        check("stream_no_stall", tot, 0);
        drain(3);

        // 3: backpressure, fill to full, then simultaneous in/out
        or3 = 1'b0;
        push(3, 8'h10, 8'h10, w);
        push(3, 8'h11, 8'h11, w);
        push(3, 8'h12, 8'h12, w);
        iv3 = 1'b1; id3 = 8'h13;
        @(negedge clk);
        check("full_in_ready", ir3, 0);
        check("full_out_valid", ov3, 1);
        check("full_out_data", od3, 8'h10);
`ifdef FGEN_PIPE_OCC_EN
        check("full_occupancy", occ3, 3);
`endif
        @(posedge clk); #1;
        or3 = 1'b1;
        push(3, 8'h13, 8'h13, w);
        check("full_simul_accept", w, 0);
`ifdef FGEN_PIPE_OCC_EN
        @(negedge clk);
        check("simul_occupancy", occ3, 3);
`endif
        drain(3);

        // 4: full pipe, enh=0 for two cycles freezes everything
        or3 = 1'b0;
        push(3, 8'h20, 8'h20, w);
        push(3, 8'h21, 8'h21, w);
        push(3, 8'h22, 8'h22, w);
        enh3 = 1'b0; or3 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("enh0_in_ready", ir3, 0);
            check("enh0_out_valid", ov3, 1);
            check("enh0_out_data", od3, 8'h20);
        end
        @(posedge clk); #1;
        enh3 = 1'b1;
        drain(3);

        // 5: full pipe, one-cycle clrh flush with out_ready high
        or3 = 1'b0;
        push(3, 8'h30, 8'h30, w);
        push(3, 8'h31, 8'h31, w);
        push(3, 8'h32, 8'h32, w);
        clrh3 = 1'b1; or3 = 1'b1;
        @(negedge clk);
        check("clr_in_ready", ir3, 0);
        @(posedge clk); #1;
        clrh3 = 1'b0; or3 = 1'b0;
        @(negedge clk);
        check("clr_out_valid", ov3, 0);
        check("clr_out_data", od3, RV);
`ifdef FGEN_PIPE_OCC_EN
        check("clr_occupancy", occ3, 0);
`endif
        @(posedge clk); #1;
        or3 = 1'b1;
        push(3, 8'h33, 8'h33, w);
        drain(3);

        // 1b: async reset mid-stream discards in-flight words
        or3 = 1'b0;
        push(3, 8'h40, 8'h40, w);
        push(3, 8'h41, 8'h41, w);
        iv3 = 1'b1; id3 = 8'h42;
        #1 rst = 1'b1;
        #1;
        check("midrst_out_valid", ov3, 0);
        check("midrst_out_data", od3, RV);
        check("midrst_in_ready", ir3, 0);
        @(negedge clk); #1;
        rst = 1'b0; iv3 = 1'b0; or3 = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_empty", ov3, 0);
        @(posedge clk); #1;

        // 6: STAGES=1, latency 1 and full throughput
        tot = 0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    push(1, s1_tab[i], s1_tab[i], w);
                    tot += w;
                end
            end
            begin
                int n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!(iv1 && ir1) && n < 20);
                @(negedge clk);
                for (int k = 0; k < 4; k++) begin
                    check("s1_valid", ov1, 1);
                    check("s1_data", od1, 8'(8'h55 + k));
                    if (k < 3) @(negedge clk);
                end
            end
        join
        check("s1_no_stall", tot, 0);
        drain(1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_funct_generator_pipe_reg
